// File: rtl/ctest_nios_leds_out.sv
// rtl/ctest_nios_leds_out.sv - Avalon-MM LED output port with set/clear and hardware blink
//
// Purpose:
//   Nios II data-master slave that drives a registered parallel output (board LEDs).
//   Software writes DATA directly or through atomic OUTSET/OUTCLEAR strobes. Bits enabled
//   in BLINK_EN are gated by a free-running phase bit that toggles every DIV+1 cycles.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   reset_n     in   1      synchronous active-low reset
//   address     in   3      register word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe (qualified by chipselect)
//   writedata   in   32     write data
//   readdata    out  32     registered read data, one-cycle latency
//   out_port    out  WIDTH  registered LED drive
//
// Register map (word address):
//   0 DATA rw, 1 BLINK_EN rw, 2 STATUS ro (bit0 = phase), 3 DIV rw,
//   4 OUTSET wo, 5 OUTCLEAR wo, 6/7 reserved (read 0, writes ignored)

module ctest_nios_leds_out #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [31:0]      DIV_RESET   = 32'd24999999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_DIV      = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] blink_en_q;
  logic [31:0]      div_q;
  logic [31:0]      count_q;
  logic             phase_q;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      data_ext;
  logic [31:0]      blink_ext;
  logic [31:0]      read_mux;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  // Zero-extend the WIDTH-bit registers to the 32-bit bus.
  always_comb begin
    data_ext                = '0;
    blink_ext               = '0;
    data_ext[WIDTH-1:0]     = data_q;
    blink_ext[WIDTH-1:0]    = blink_en_q;
  end

  // Read mux sees the pre-edge register values, so a read in the same cycle
  // as a write to that register returns the old contents.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:     read_mux = data_ext;
      ADDR_BLINK_EN: read_mux = blink_ext;
      ADDR_STATUS:   read_mux = {31'b0, phase_q};
      ADDR_DIV:      read_mux = div_q;
      default:       read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      div_q      <= DIV_RESET;
      count_q    <= DIV_RESET;
      phase_q    <= 1'b0;
      out_port   <= RESET_VALUE;
      readdata   <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:     data_q     <= wr_bits;
          ADDR_BLINK_EN: blink_en_q <= wr_bits;
          ADDR_OUTSET:   data_q     <= data_q | wr_bits;
          ADDR_OUTCLEAR: data_q     <= data_q & ~wr_bits;
          default:       ;
        endcase
      end

      // A DIV write restarts the count from the new value and suppresses any
      // toggle that would have happened on this edge, leaving phase as-is.
      if (wr_en && (address == ADDR_DIV)) begin
        div_q   <= writedata;
        count_q <= writedata;
      end else if (count_q == 32'd0) begin
        phase_q <= ~phase_q;
        count_q <= div_q;
      end else begin
        count_q <= count_q - 32'd1;
      end

      // Blinking bits are forced low while phase is 0.
      out_port <= data_q & ~(blink_en_q & {WIDTH{~phase_q}});
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_ctest_nios_leds_out.sv
// tb/tb_ctest_nios_leds_out.sv - scoreboard bench for ctest_nios_leds_out

module tb_ctest_nios_leds_out;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;
  localparam logic [31:0] DR = 32'd19;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_out[$];
  logic [31:0] q_rd[$];

  ctest_nios_leds_out #(
    .WIDTH(W),
    .RESET_VALUE(RV),
    .DIV_RESET(DR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] d);
    reset_n    = rn;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
  endtask

  // Push the expectations for the edge about to happen, clock it, then pop and compare.
  task automatic step(input string tag, input bit co, input logic [7:0] eo,
                      input bit cr, input logic [31:0] er);
    if (co) q_out.push_back({24'b0, eo});
    if (cr) q_rd.push_back(er);
    @(posedge clk);
    #1;
    if (co) check({tag, "/out"}, {24'b0, out_port}, q_out.pop_front());
    if (cr) check({tag, "/rd"}, readdata, q_rd.pop_front());
  endtask

  // Phase j edges after a reference edge that left phase=p0 and count=div.
  function automatic bit phase_at(input int j, input int div, input bit p0);
    return p0 ^ bit'((j / (div + 1)) & 1);
  endfunction

  function automatic logic [7:0] exp_out(input logic [7:0] d, input logic [7:0] b, input bit ph);
    return d & ~(b & {8{~ph}});
  endfunction

  // Reset edge with a coincident DATA write that must be ignored.
  task automatic do_reset(input string tag);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
    step(tag, 1'b1, RV, 1'b1, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  // STATUS reads over edges jf..jt; checks out_port and the phase bit.
  task automatic blink_run(input string tag, input int jf, input int jt, input int div,
                           input bit p0, input logic [7:0] d, input logic [7:0] b);
    bit ph;
    for (int j = jf; j <= jt; j++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd2, 32'd0);
      ph = phase_at(j - 1, div, p0);
      step(tag, 1'b1, exp_out(d, b, ph), 1'b1, {31'b0, ph});
    end
  endtask

  initial begin
    bit p1;

    // Reset state and reset values
    do_reset("rst0");
    do_reset("rst1");
    drive(1'b1, 1'b1, 1'b1, 3'd3, 32'd0); step("rd_div_rst", 1'b1, RV, 1'b1, DR);
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd0); step("rd_data_rst", 1'b1, RV, 1'b1, {24'b0, RV});
    drive(1'b1, 1'b1, 1'b1, 3'd1, 32'd0); step("rd_blink_rst", 1'b1, RV, 1'b1, 32'd0);

    // DATA / OUTSET / OUTCLEAR
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_000F); step("wr_data", 1'b1, RV, 1'b1, {24'b0, RV});
    drive(1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_0030); step("outset", 1'b1, 8'h0F, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd5, 32'h0000_0005); step("outclr", 1'b1, 8'h3F, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd0);         step("rd_setclr", 1'b1, 8'h3A, 1'b1, 32'h0000_003A);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);         step("idle_setclr", 1'b1, 8'h3A, 1'b1, 32'h0000_003A);

    // DIV=3 blink on bits 7 and 0
    do_reset("rst_b3");
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'd3);    step("b3_div", 1'b1, RV, 1'b1, DR);
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'hFF);   step("b3_data", 1'b1, RV, 1'b1, {24'b0, RV});
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h81);   step("b3_blink", 1'b1, 8'hFF, 1'b1, 32'd0);
    blink_run("b3", 3, 20, 3, 1'b0, 8'hFF, 8'h81);

    // DIV=0 toggles every cycle, then DIV=9 restarts a 10-cycle half period
    do_reset("rst_b0");
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'd0);    step("b0_div", 1'b1, RV, 1'b1, DR);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h01);   step("b0_blink", 1'b1, RV, 1'b1, 32'd0);
    blink_run("b0", 2, 9, 0, 1'b0, RV, 8'h01);
    p1 = phase_at(9, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'd9);    step("b9_div", 1'b1, exp_out(RV, 8'h01, p1), 1'b1, 32'd0);
    blink_run("b9", 1, 25, 9, p1, RV, 8'h01);

    // Same-address read/write latency, reserved addresses, upper-bit masking
    do_reset("rst_rw");
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'hDEAD_BE5A); step("rw_wr0", 1'b1, RV, 1'b1, {24'b0, RV});
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd0);         step("rw_rd0", 1'b1, 8'h5A, 1'b1, 32'h0000_005A);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'hFFFF_FF3C); step("rw_wr1", 1'b1, 8'h5A, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd1, 32'd0);         step("rw_rd1", 1'b1, 8'h42, 1'b1, 32'h0000_003C);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'd0);         step("rw_wr1b", 1'b1, 8'h42, 1'b1, 32'h0000_003C);
    for (int a = 4; a <= 7; a++) begin
      drive(1'b1, 1'b1, 1'b1, 3'(a), 32'd0);
      step($sformatf("rd_addr%0d", a), 1'b1, 8'h5A, 1'b1, 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF); step("wr6", 1'b1, 8'h5A, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF); step("wr7", 1'b1, 8'h5A, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd0);         step("post67_data", 1'b1, 8'h5A, 1'b1, 32'h0000_005A);
    drive(1'b1, 1'b1, 1'b1, 3'd1, 32'd0);         step("post67_blink", 1'b1, 8'h5A, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd3, 32'd0);         step("post67_div", 1'b1, 8'h5A, 1'b1, DR);

    // Reset in the middle of a blink period
    do_reset("rst_mid");
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'hFF);   step("mid_data", 1'b1, RV, 1'b1, {24'b0, RV});
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'hFF);   step("mid_blink", 1'b1, 8'hFF, 1'b1, 32'd0);
    blink_run("mid", 3, 30, int'(DR), 1'b0, 8'hFF, 8'hFF);
    do_reset("rst_mid_hit");
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd0);    step("mid_rd_data", 1'b1, RV, 1'b1, {24'b0, RV});
    drive(1'b1, 1'b1, 1'b1, 3'd1, 32'd0);    step("mid_rd_blink", 1'b1, RV, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd3, 32'd0);    step("mid_rd_div", 1'b1, RV, 1'b1, DR);
    drive(1'b1, 1'b1, 1'b1, 3'd2, 32'd0);    step("mid_rd_stat", 1'b1, RV, 1'b1, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h01);   step("mid_blink2", 1'b1, RV, 1'b1, 32'd0);
    blink_run("restart", 6, 45, int'(DR), 1'b0, RV, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctest_nios_leds_out.md
# ctest_nios_leds_out

Avalon-MM write/read slave that drives a registered parallel output port (board LEDs) from the Nios II data master. It is the output-direction counterpart of the switch input PIO on the same system interconnect. It adds atomic bit set/clear registers and a per-bit hardware blink function driven by a programmable prescaler, so software can blink LEDs without polling.

## Interface
- WIDTH, 8: width of out_port and of the DATA/BLINK_EN registers (1..32).
- RESET_VALUE, 0: value loaded into DATA at reset (WIDTH bits).
- DIV_RESET, 24999999: value loaded into DIV at reset; blink half-period = DIV+1 cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset is synchronous and active-low.
- address  in  3  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, valid only with chipselect=1.
- writedata  in  32  write data.
- readdata  out  32  registered read data, 1-cycle read latency.
- out_port  out  WIDTH  registered LED drive.

## Operation
- Register map (word address):
  - 0 DATA, rw, WIDTH bits.
  - 1 BLINK_EN, rw, WIDTH bits; 1 = bit blinks.
  - 2 STATUS, ro; bit0 = blink phase, others 0.
  - 3 DIV, rw, 32 bits.
  - 4 OUTSET, wo; DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
  - 5 OUTCLEAR, wo; DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
  - 6, 7: writes ignored, reads return 0.
- Write accepted when chipselect=1 and write_n=0; no wait states. Upper unused writedata bits are ignored; upper readdata bits read 0.
- Prescaler:
  - 32-bit down-counter. When count==0: toggle phase and reload count from DIV. Otherwise decrement.
  - Writing DIV updates DIV and loads count with the new value in the same edge. Phase is unchanged.
  - DIV=0 toggles phase every cycle.
- Output: out_port <= DATA & ~(BLINK_EN & {WIDTH{~phase}}). Non-blinking bits follow DATA; blinking bits show DATA while phase=1 and 0 while phase=0.
- Read path: readdata <= mux(address) every clock, independent of chipselect.
- Reset (reset_n=0 at a rising edge):
  - DATA=RESET_VALUE, BLINK_EN=0, DIV=DIV_RESET, count=DIV_RESET, phase=0.
  - out_port=RESET_VALUE, readdata=0.
  - Reset mid-blink or mid-transfer discards all state. A write coincident with reset is ignored.

## Timing
- Write sampled at edge N: register updated at edge N; out_port reflects it at edge N+1.
- Read: address sampled at edge N; readdata valid after edge N (latency 1). Back-to-back reads supported every cycle.
- Read of a register written in the same edge returns the old value. The read on the next cycle returns the new value.
- Phase toggles exactly every DIV+1 cycles. out_port follows the phase change one edge later.
- Only one access per cycle, so OUTSET/OUTCLEAR/DATA conflicts cannot occur. A DATA write and a phase toggle on the same edge are both applied.

## Test plan
- Reset with RESET_VALUE=8'hA5: out_port=8'hA5 and readdata=0 after the first edge with reset_n=0. Read addr 3 returns DIV_RESET.
- Write DATA=8'h0F, then OUTSET 8'h30, then OUTCLEAR 8'h05: out_port sequence is 8'h0F, 8'h3F, 8'h3A, each one edge after its write. Read addr 0 returns 32'h0000003A.
- DIV=3, DATA=8'hFF, BLINK_EN=8'h81: bits 7 and 0 toggle every 4 cycles while bits 6..1 stay 1. STATUS bit0 matches the phase.
- DIV=0 with BLINK_EN=8'h01: out_port[0] alternates every cycle. Then write DIV=9: next toggle comes 10 cycles after the write edge.
- Read and write at the same address on consecutive cycles: readdata latency is exactly 1. Reads of addresses 4 through 7 return 0. Writes to 6 and 7 change nothing.
- Assert reset_n=0 for one cycle mid-blink (phase=1, count mid-range): all registers return to reset values, out_port=RESET_VALUE, and phase restarts at 0 with a full DIV_RESET+1 period.
